// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control sequencer that drives the 16-bit add/sub/xor ALU.
// Define ALU_SEQ_OVF_EN to build the sticky signed-overflow flag; otherwise ovf is tied low.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] alu_out,
  output logic [15:0] a_out,
  output logic [15:0] b_out,
  output logic        a_enable,
  output logic        acc_enable,
  output logic        addsub,
  output logic        xor_ctrl,
  output logic        done,
  output logic [15:0] op_count,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_XOR    = 3'd3;
  localparam logic [2:0] OP_ADDACC = 3'd4;
  localparam logic [2:0] OP_SUBACC = 3'd5;
  localparam logic [2:0] OP_XORACC = 3'd6;
  localparam logic [2:0] OP_CLR    = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] b_cap_q, b_cap_d;
  logic [15:0] a_out_q, a_out_d;
  logic [15:0] b_out_q, b_out_d;
  logic [15:0] op_count_q, op_count_d;
  logic        in_ready_q, in_ready_d;
  logic        a_enable_q, a_enable_d;
  logic        acc_enable_q, acc_enable_d;
  logic        addsub_q, addsub_d;
  logic        xor_ctrl_q, xor_ctrl_d;
  logic        done_q, done_d;
  logic        accept;

  function automatic logic is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SUBACC);
  endfunction

  function automatic logic is_xor(input logic [2:0] op);
    return (op == OP_XOR) || (op == OP_XORACC);
  endfunction

  // The accumulator only moves on acc_enable in EXEC, so alu_out captured at the
  // accept edge equals what the ALU presents during LOAD_A.
  always_comb begin
    accept       = in_valid && in_ready_q;
    state_d      = state_q;
    op_d         = op_q;
    b_cap_d      = b_cap_q;
    a_out_d      = a_out_q;
    b_out_d      = b_out_q;
    op_count_d   = op_count_q;
    a_enable_d   = 1'b0;
    acc_enable_d = 1'b0;
    addsub_d     = 1'b0;
    xor_ctrl_d   = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d    = in_op;
          b_cap_d = in_b;
          if (in_op == OP_NOP) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = LOAD_A;
            a_enable_d = 1'b1;
            case (in_op)
              OP_ADD, OP_SUB, OP_XOR:          a_out_d = in_a;
              OP_ADDACC, OP_SUBACC, OP_XORACC: a_out_d = alu_out;
              default:                         a_out_d = 16'h0000;
            endcase
          end
        end
      end
      LOAD_A: begin
        state_d      = EXEC;
        acc_enable_d = 1'b1;
        b_out_d      = (op_q == OP_CLR) ? 16'h0000 : b_cap_q;
        addsub_d     = is_sub(op_q);
        xor_ctrl_d   = is_xor(op_q);
      end
      EXEC: begin
        state_d    = DONE;
        done_d     = 1'b1;
        op_count_d = op_count_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_NOP;
      b_cap_q      <= 16'h0000;
      a_out_q      <= 16'h0000;
      b_out_q      <= 16'h0000;
      op_count_q   <= 16'h0000;
      in_ready_q   <= 1'b1;
      a_enable_q   <= 1'b0;
      acc_enable_q <= 1'b0;
      addsub_q     <= 1'b0;
      xor_ctrl_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      b_cap_q      <= b_cap_d;
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
      op_count_q   <= op_count_d;
      in_ready_q   <= in_ready_d;
      a_enable_q   <= a_enable_d;
      acc_enable_q <= acc_enable_d;
      addsub_q     <= addsub_d;
      xor_ctrl_q   <= xor_ctrl_d;
      done_q       <= done_d;
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  function automatic logic is_add(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADDACC);
  endfunction

  // a_out/b_out still hold the operands in DONE, so no separate shadow is needed.
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == EXEC) && (op_q == OP_CLR)) begin
      ovf_d = 1'b0;
    end else if (state_q == DONE) begin
      if (is_add(op_q) && (a_out_q[15] == b_out_q[15]) && (alu_out[15] != a_out_q[15]))
        ovf_d = 1'b1;
      if (is_sub(op_q) && (a_out_q[15] != b_out_q[15]) && (alu_out[15] != a_out_q[15]))
        ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign a_out      = a_out_q;
  assign b_out      = b_out_q;
  assign a_enable   = a_enable_q;
  assign acc_enable = acc_enable_q;
  assign addsub     = addsub_q;
  assign xor_ctrl   = xor_ctrl_q;
  assign done       = done_q;
  assign op_count   = op_count_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control sequencer directly upstream of the 16-bit add/sub/xor ALU datapath. It accepts one operation per valid/ready handshake and drives the ALU's operand buses and its a_enable, acc_enable, addsub and xor_ctrl strobes in the required order. It reads the ALU accumulator back for chained operations. It reports completion, a completed-operation count and, optionally, a sticky signed-overflow flag.

## Interface
- No parameters; datapath width fixed at 16.
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset; shared with the ALU
- in_valid  input  1  operation request
- in_ready  output  1  sequencer can accept; high in IDLE and DONE
- in_op  input  3  opcode: 0 NOP, 1 ADD, 2 SUB, 3 XOR, 4 ADDACC, 5 SUBACC, 6 XORACC, 7 CLR
- in_a  input  16  A operand (ignored by *ACC ops and CLR)
- in_b  input  16  B operand (ignored by CLR)
- alu_out  input  16  ALU accumulator output
- a_out  output  16  to ALU a
- b_out  output  16  to ALU b
- a_enable  output  1  ALU A-register load strobe
- acc_enable  output  1  ALU accumulator load strobe
- addsub  output  1  0 add, 1 subtract
- xor_ctrl  output  1  1 selects XOR result
- done  output  1  one-cycle pulse; alu_out holds the result in this cycle
- op_count  output  16  completed non-NOP operations, wraps 0xFFFF→0
- ovf  output  1  sticky signed overflow (see Configuration)

## Operation
- FSM states: IDLE, LOAD_A, EXEC, DONE.
- Accept: in_valid && in_ready at a rising edge. The edge captures in_op and in_b.
  - Non-NOP → LOAD_A.
  - NOP → DONE.
- LOAD_A:
  - a_out = in_a captured at accept for ADD/SUB/XOR, alu_out sampled this cycle for *ACC ops, 0 for CLR.
  - a_enable=1. → EXEC.
- EXEC:
  - b_out = captured in_b (0 for CLR).
  - addsub=1 for SUB/SUBACC, else 0.
  - xor_ctrl=1 for XOR/XORACC, else 0.
  - acc_enable=1. → DONE.
- DONE:
  - done=1.
  - op_count increments unless the op was NOP.
  - If in_valid, accept next op (→ LOAD_A or DONE); else → IDLE.
- a_out/b_out registered; hold values between ops. addsub/xor_ctrl return to 0 outside EXEC.
- Strobes are never asserted outside their own state; a_enable and acc_enable are never high together.
- in_op/in_a/in_b changes after accept have no effect.

## Timing
- Latency: accept edge → LOAD_A (1) → EXEC (2) → DONE (3); result on alu_out during DONE.
- Back-to-back throughput is one op per 3 cycles. A NOP takes 1 cycle (accept → DONE).
- Reset values: state IDLE, in_ready=1, a_out=b_out=0, all strobes 0, done=0, op_count=0, ovf=0.
- rst mid-operation aborts the operation immediately:
  - no done pulse;
  - op_count unchanged from 0;
  - the ALU accumulator also clears, since reset is shared.
- in_valid while in LOAD_A/EXEC: in_ready=0, no accept; the request must stay asserted.

## Configuration
- ALU_SEQ_OVF_EN defined:
  - In DONE, for ADD/ADDACC, ovf sets if a[15]==b[15] && alu_out[15]!=a[15].
  - For SUB/SUBACC, ovf sets if a[15]!=b[15] && alu_out[15]!=a[15].
  - a is the value driven in LOAD_A.
  - ovf is sticky; cleared only by rst or a completed CLR (cleared in CLR's DONE cycle).
- ALU_SEQ_OVF_EN undefined: ovf tied 0; no a-shadow or overflow logic synthesized.

## Test plan
- Reset then ADD in_a=0x1234, in_b=0x0011:
  - a_enable high cycle 1, acc_enable cycle 2, done cycle 3;
  - alu_out=0x1245, op_count=1.
- SUB 0x0005−0x0007 → alu_out=0xFFFE with addsub=1 in EXEC only; XOR 0xF0F0^0x0FF0 → 0xFF00 with xor_ctrl=1 in EXEC only.
- Chain ADD 3,4 then ADDACC in_b=0x000A with in_valid held high:
  - second op accepted in the first op's DONE;
  - done pulses 3 cycles apart; final alu_out=0x0011.
- With ALU_SEQ_OVF_EN: ADD 0x7FFF+0x0001 → alu_out=0x8000 and ovf=1. A following ADD 1+1 keeps ovf=1. CLR → alu_out=0x0000 and ovf=0.
- NOP → done one cycle after accept, no strobes, op_count unchanged.
- rst asserted during EXEC of SUB:
  - all outputs to reset values asynchronously, no done pulse;
  - next ADD after release completes normally with op_count=1.
